// File: rtl/vram_uart_dump_pkg.sv
// Shared types and constants for the VRAM-to-UART text dump engine.
// Holds the FSM state encodings, the framing bytes and the printable-byte filter.
package vram_uart_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        SEND,
        TXW,
        CR,
        LF,
        FIN
    } state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_SEND,
        HS_GUARD,
        HS_WAIT
    } hs_state_e;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_SUB = 8'h2E;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    // Non-printable cells are shown as '.' so the terminal stays sane.
    function automatic logic [7:0] sanitize(input logic [7:0] b);
        return (b >= PRINT_LO && b <= PRINT_HI) ? b : CHAR_SUB;
    endfunction

endpackage

// File: rtl/vram_uart_dump_tx_byte_handshake.sv
// One-byte transmit handshake: holds a byte, pulses tx_ready when the
// transmitter is idle, skips a guard cycle, then waits for tx_busy to drop.
// Ports: clk, reset, start/byte_in (load request), tx_busy (from transmitter),
//        tx_data/tx_ready (to transmitter), done (completion strobe).
module tx_byte_handshake
    import vram_uart_dump_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       done
);

    hs_state_e  state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       free;

    // tx_ready is gated directly by tx_busy so it can never overlap a busy
    // transmitter, even if busy is raised externally without warning.
    assign tx_ready = (state_q == HS_SEND) && !tx_busy;
    assign done     = (state_q == HS_WAIT) && !tx_busy;
    assign free     = (state_q == HS_IDLE) || done;
    assign tx_data  = data_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            HS_IDLE:  state_d = HS_IDLE;
            HS_SEND:  if (!tx_busy) state_d = HS_GUARD;
            // tx_busy may only rise here, one cycle after the strobe
            HS_GUARD: state_d = HS_WAIT;
            HS_WAIT:  if (!tx_busy) state_d = HS_IDLE;
            default:  state_d = HS_IDLE;
        endcase
        // A new byte may be loaded in the same cycle the previous completes.
        if (start && free) begin
            data_d  = byte_in;
            state_d = HS_SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HS_IDLE;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/vram_uart_dump.sv
// Text-screen dump engine: on the trigger byte, reads VRAM row by row and
// streams every cell (sanitised) to the UART, ending each row with CR/LF.
// Ports: clk, reset, rx_data/rx_ready (receiver), ram_ce/ram_addr/ram_data
//        (VRAM read port), tx_data/tx_ready/tx_busy (transmitter), busy, done.
module vram_uart_dump
    import vram_uart_dump_pkg::*;
#(
    parameter int         COLS    = 50,
    parameter int         ROWS    = 15,
    parameter int         ADDR_W  = 12,
    parameter logic [7:0] TRIGGER = 8'h12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              ram_ce,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic [7:0]        tx_data,
    output logic              tx_ready,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = $clog2(COLS + 1);
    localparam int ROW_W = $clog2(ROWS + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              ram_ce_q, ram_ce_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              hs_start;
    logic [7:0]        hs_byte;
    logic              hs_ready;
    logic              hs_done;

    logic [ADDR_W-1:0] addr_inc;
    logic [COL_W-1:0]  col_inc;
    logic [ROW_W-1:0]  row_inc;

    assign addr_inc = addr_q + ADDR_W'(1);
    assign col_inc  = col_q + COL_W'(1);
    assign row_inc  = row_q + ROW_W'(1);

    tx_byte_handshake u_hs (
        .clk      (clk),
        .reset    (reset),
        .start    (hs_start),
        .byte_in  (hs_byte),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_ready (hs_ready),
        .done     (hs_done)
    );

    assign tx_ready = hs_ready;
    assign ram_ce   = ram_ce_q;
    assign ram_addr = ram_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        col_d      = col_q;
        row_d      = row_q;
        ram_ce_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hs_start   = 1'b0;
        hs_byte    = sanitize(ram_data);
        unique case (state_q)
            IDLE: begin
                if (rx_ready && rx_data == TRIGGER) begin
                    addr_d     = '0;
                    col_d      = '0;
                    row_d      = '0;
                    busy_d     = 1'b1;
                    ram_ce_d   = 1'b1;
                    ram_addr_d = '0;
                    state_d    = RD;
                end
            end
            RD:  state_d = RDW;
            // Read data is valid now; the handshake latches it sanitised.
            RDW: begin
                hs_start = 1'b1;
                state_d  = SEND;
            end
            SEND: if (hs_ready) state_d = TXW;
            TXW: begin
                if (hs_done) begin
                    addr_d = addr_inc;
                    if (col_inc == COL_W'(COLS)) begin
                        col_d    = '0;
                        hs_start = 1'b1;
                        hs_byte  = CHAR_CR;
                        state_d  = CR;
                    end else begin
                        col_d      = col_inc;
                        ram_ce_d   = 1'b1;
                        ram_addr_d = addr_inc;
                        state_d    = RD;
                    end
                end
            end
            CR: begin
                if (hs_done) begin
                    hs_start = 1'b1;
                    hs_byte  = CHAR_LF;
                    state_d  = LF;
                end
            end
            LF: begin
                if (hs_done) begin
                    row_d = row_inc;
                    if (row_inc == ROW_W'(ROWS)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        ram_ce_d   = 1'b1;
                        ram_addr_d = addr_q;
                        state_d    = RD;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            ram_ce_q   <= 1'b0;
            ram_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ram_ce_q   <= ram_ce_d;
            ram_addr_q <= ram_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_vram_uart_dump.sv
// Directed bench for vram_uart_dump with a VRAM model and a transmitter
// model that stays busy for ten cycles after each tx_ready strobe.
module tb_vram_uart_dump;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        ram_ce;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_busy;
    logic        busy;
    logic        done;

    vram_uart_dump dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .ram_ce   (ram_ce),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] vram [0:749];
    int         tx_cnt = 0;
    logic       bp = 1'b0;

    always @(posedge clk) begin
        if (ram_ce) ram_data <= (ram_addr < 12'd750) ? vram[ram_addr] : 8'h00;
    end

    always @(posedge clk) begin
        if (tx_ready) tx_cnt <= 10;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end

    assign tx_busy = (tx_cnt != 0) || bp;

    logic [7:0] got [$];
    int   total = 0;
    int   passed = 0;
    int   failed = 0;
    int   reads = 0;
    int   exp_addr = 0;
    int   ord_err = 0;
    int   proto_err = 0;
    int   bp_err = 0;
    int   done_cnt = 0;
    logic bp_chk = 1'b0;
    logic busy_seen = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_ce = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All sampling happens here, on the falling edge, in a single process.
    task automatic tick();
        @(negedge clk);
        if (tx_ready) begin
            got.push_back(tx_data);
            if (tx_busy) proto_err++;
            if (prev_ready) proto_err++;
            if (bp_chk) bp_err++;
        end
        if (ram_ce) begin
            if (int'(ram_addr) != exp_addr) ord_err++;
            if (prev_ce) proto_err++;
            if (bp_chk) bp_err++;
            exp_addr++;
            reads++;
        end
        if (done) done_cnt++;
        if (busy) busy_seen = 1'b1;
        prev_ready = tx_ready;
        prev_ce    = ram_ce;
    endtask

    function automatic logic [7:0] gb(input int i);
        return (i < got.size()) ? got[i] : 8'h00;
    endfunction

    function automatic logic [7:0] printable(input logic [7:0] b);
        return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h2E;
    endfunction

    function automatic int stream_errs();
        int e = 0;
        int k = 0;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 50; c++) begin
                if (gb(k) != printable(vram[r * 50 + c])) e++;
                k++;
            end
            if (gb(k) != 8'h0D) e++;
            if (gb(k + 1) != 8'h0A) e++;
            k += 2;
        end
        if (got.size() != 780) e++;
        return e;
    endfunction

    task automatic begin_dump();
        got.delete();
        reads    = 0;
        exp_addr = 0;
        ord_err  = 0;
        done_cnt = 0;
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k = 0;
        while (got.size() < n && k < 20000) begin
            tick();
            k++;
        end
        check(tag, got.size() >= n, 1);
    endtask

    task automatic run_to_done(input string tag);
        int k = 0;
        while (done_cnt == 0 && k < 20000) begin
            tick();
            k++;
        end
        check(tag, done_cnt != 0, 1);
        repeat (30) tick();
    endtask

    task automatic fill_alpha();
        for (int i = 0; i < 750; i++) vram[i] = 8'h41 + 8'(i % 26);
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        ram_data = 8'h00;
        fill_alpha();
        repeat (3) tick();
        check("rst_ram_ce", ram_ce, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        tick();

        // Non-trigger byte is ignored.
        begin_dump();
        busy_seen = 1'b0;
        strobe(8'h41);
        repeat (20) tick();
        check("nontrig_reads", reads, 0);
        check("nontrig_tx", got.size(), 0);
        check("nontrig_busy", busy_seen, 0);

        // Full dump with startup timing.
        begin_dump();
        strobe(8'h12);
        check("t1_busy", busy, 1);
        check("t1_ram_ce", ram_ce, 1);
        check("t1_ram_addr", ram_addr, 0);
        tick();
        check("t2_ram_ce", ram_ce, 0);
        check("t2_tx_ready", tx_ready, 0);
        tick();
        check("t3_tx_ready", tx_ready, 1);
        check("t3_tx_data", tx_data, 8'h41);
        run_to_done("dump1_done_timeout");
        check("dump1_bytes", got.size(), 780);
        check("dump1_reads", reads, 750);
        check("dump1_order", ord_err, 0);
        check("dump1_done_cnt", done_cnt, 1);
        check("dump1_busy_after", busy, 0);
        check("row0_c0", gb(0), 8'h41);
        check("row0_c25", gb(25), 8'h5A);
        check("row0_c26", gb(26), 8'h41);
        check("row0_c49", gb(49), 8'h58);
        check("row0_cr", gb(50), 8'h0D);
        check("row0_lf", gb(51), 8'h0A);
        check("last_char", gb(777), 8'h56);
        check("dump1_stream", stream_errs(), 0);

        // Sanitisation, trigger while busy and back-pressure in one dump.
        vram[0] = 8'h00;
        vram[1] = 8'h7F;
        vram[2] = 8'h41;
        vram[3] = 8'hFF;
        begin_dump();
        strobe(8'h12);
        wait_bytes(100, "dump2_wait100");
        strobe(8'h12);
        wait_bytes(300 + int'($urandom_range(0, 200)), "dump2_wait_bp");
        begin
            int n_bp;
            int r_bp;
            bp = 1'b1;
            tick();
            bp_chk = 1'b1;
            n_bp = got.size();
            r_bp = reads;
            repeat (500) tick();
            check("bp_no_tx", got.size(), n_bp);
            check("bp_no_read", reads, r_bp);
            bp_chk = 1'b0;
            bp = 1'b0;
        end
        run_to_done("dump2_done_timeout");
        check("san0", gb(0), 8'h2E);
        check("san1", gb(1), 8'h2E);
        check("san2", gb(2), 8'h41);
        check("san3", gb(3), 8'h2E);
        check("dump2_bytes", got.size(), 780);
        check("dump2_done_cnt", done_cnt, 1);
        check("dump2_order", ord_err, 0);
        check("dump2_bp_err", bp_err, 0);
        check("dump2_stream", stream_errs(), 0);

        // Reset in the middle of a dump, then a fresh full dump.
        fill_alpha();
        begin_dump();
        strobe(8'h12);
        wait_bytes(300, "dump3_wait300");
        reset = 1'b1;
        tick();
        check("mid_rst_ram_ce", ram_ce, 0);
        check("mid_rst_ram_addr", ram_addr, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_tx_ready", tx_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        reset = 1'b0;
        begin
            int n0;
            n0 = got.size();
            repeat (50) tick();
            check("mid_rst_no_tx", got.size(), n0);
        end
        begin_dump();
        strobe(8'h12);
        check("dump4_first_addr", ram_addr, 0);
        run_to_done("dump4_done_timeout");
        check("dump4_bytes", got.size(), 780);
        check("dump4_reads", reads, 750);
        check("dump4_order", ord_err, 0);
        check("dump4_done_cnt", done_cnt, 1);
        check("dump4_stream", stream_errs(), 0);

        check("protocol", proto_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vram_uart_dump.md
# vram_uart_dump

Text-screen dump engine: on a trigger byte from the UART receiver, it reads the character VRAM row by row through a read port and streams the contents out through the UART transmitter. Each row is terminated with CR/LF. It is the read-back counterpart of the path that writes received characters into VRAM. It sits on `clk_72m` between `uart_rx`, the VRAM read port and `uart_tx`.

## Interface
- `COLS`, 50, characters per row
- `ROWS`, 15, rows per screen (COLS*ROWS = 750 cells)
- `ADDR_W`, 12, VRAM address width
- `TRIGGER`, 8'h12, rx byte that starts a dump (Ctrl-R)
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `rx_data`  in  8  received byte, valid while `rx_ready`=1
- `rx_ready`  in  1  one-cycle strobe from the receiver
- `ram_ce`  out  1  VRAM read enable
- `ram_addr`  out  ADDR_W  VRAM read address
- `ram_data`  in  8  VRAM read data, valid the cycle after `ram_ce`
- `tx_data`  out  8  byte to transmit
- `tx_ready`  out  1  one-cycle send strobe to the transmitter
- `tx_busy`  in  1  transmitter busy; rises the cycle after `tx_ready` is sampled
- `busy`  out  1  high from trigger acceptance until the last byte completes
- `done`  out  1  one-cycle pulse when the dump completes

## Operation
- States: IDLE, RD, RDW, SEND, TXW, CR, LF, FIN.
- IDLE:
  - `rx_ready`=1 with `rx_data`==TRIGGER → clear addr, col, row → RD.
  - Any other byte is ignored.
- RD: drive `ram_ce`=1 and `ram_addr`=addr for one cycle → RDW.
- RDW: latch `ram_data`, sanitised → SEND.
  - Bytes 0x20..0x7E pass through unchanged.
  - All other bytes become 0x2E ('.').
- SEND:
  - Waits while `tx_busy`=1.
  - Once `tx_busy`=0: `tx_ready`=1 for one cycle with the held byte → TXW.
- TXW:
  - Skips the first cycle (guard cycle).
  - Then waits for `tx_busy`=0.
  - Then increments addr and col.
  - col==COLS → col=0 → CR; otherwise → RD.
- CR / LF: each sends one byte (0x0D, then 0x0A) using the same SEND/TXW handshake. After LF, row increments.
  - row==ROWS → FIN.
  - Otherwise → RD.
- FIN: `done`=1 for one cycle → IDLE.
- Totals: exactly ROWS*(COLS+2) = 780 bytes per dump and COLS*ROWS = 750 VRAM reads, addresses 0..749 in ascending order, each read once.
- Counter widths:
  - addr is ADDR_W bits and never exceeds COLS*ROWS-1 when driven.
  - col is clog2(COLS+1) bits; row is clog2(ROWS+1) bits.
- A TRIGGER received while `busy`=1 is ignored; no queuing, no restart.
- VRAM contents changing mid-dump is allowed; each cell is sampled at its own read.

## Timing
- Reset values: `ram_ce`=0, `ram_addr`=0, `tx_data`=0, `tx_ready`=0, `busy`=0, `done`=0, state IDLE.
- Reset mid-dump: abort on the next edge with no further `tx_ready` pulses. A byte already handed to the transmitter finishes there.
- `busy` rises the cycle after the trigger strobe and falls in the same cycle `done` pulses.
- Trigger to first `tx_ready`: 3 cycles (RD, RDW, SEND) if `tx_busy`=0.
- `tx_ready` is never asserted while `tx_busy`=1 and never on two consecutive cycles.
- `ram_ce` is high for exactly one cycle per read, and never while a byte is pending transmission.
- `tx_data` is stable from the `tx_ready` cycle until the next byte is loaded.

## Structure
- Shared package holds:
  - the state enum;
  - the constants CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_SUB=8'h2E and the printable bounds 8'h20/8'h7E.
- One natural sub-module: `tx_byte_handshake`. It implements the SEND/TXW protocol (byte in + start → `tx_ready` pulse, guard cycle, completion strobe) and is reused for character and CR/LF bytes.
- Everything else stays flat in `vram_uart_dump`.

## Test plan
- Reset then trigger:
  - Stimulus: VRAM filled with 'A'+(addr%26); one 0x12 strobe; transmitter model with a 10-cycle busy period.
  - Required: 780 bytes. Row 0 is 'A'..'Z','A'..'X' followed by 0x0D 0x0A. Exactly one `done` pulse.
- Sanitisation:
  - Stimulus: cells 0..3 = 0x00, 0x7F, 0x41, 0xFF.
  - Required: first four tx bytes are 0x2E, 0x2E, 0x41, 0x2E.
- Non-trigger byte:
  - Stimulus: `rx_data`=0x41 strobe.
  - Required: no `ram_ce`, no `tx_ready`, `busy` stays 0.
- Trigger while busy:
  - Stimulus: a second 0x12 strobe during byte 100.
  - Required: total remains 780 bytes and a single `done` pulse.
- Reset at byte 300:
  - Required: all outputs return to their reset values on the next edge, no further `tx_ready` pulses, and a fresh trigger produces a full 780-byte dump starting at address 0.
- Back-pressure:
  - Stimulus: `tx_busy` held high for 500 cycles at a random point.
  - Required: no `tx_ready` and no `ram_ce` during that window, and the byte order is unchanged.
